muldiv_fu: RTL and testbench

//  Parametrised RV32M functional unit for the OOO core, successor to the single-cycle ALU/CMP units.

---
 rtl/muldiv_fu.sv | 259 +++++++++++++++++++++++++
 tb/tb_muldiv_fu.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_fu.sv
// muldiv_fu: RV32M functional unit.
//   Pipelined multiplier (MUL/MULH/MULHSU/MULHU) and iterative radix-2
//   restoring divider (DIV/DIVU/REM/REMU) sharing one result register
//   that drives a single CDB port with a valid/ready handshake.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   flush         kill every in-flight op (synchronous, highest priority)
//   in_valid      reservation station presents an op
//   in_op         funct3 (in_op[2]=1 selects the divider)
//   in_src1/2     operands
//   in_rob_idx    destination ROB tag
//   in_ready_mul  multiplier stage 0 can accept this cycle
//   in_ready_div  divider is idle
//   out_valid     result register holds a result
//   out_ready     CDB grant; transfer on out_valid && out_ready
//   out_value     result value
//   out_dest_rob  ROB tag of the result
module muldiv_fu #(
    parameter int XLEN       = 32,
    parameter int ROB_W      = 4,
    parameter int MUL_STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [ROB_W-1:0] in_rob_idx,
    output logic             in_ready_mul,
    output logic             in_ready_div,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_value,
    output logic [ROB_W-1:0] out_dest_rob
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int HEAD  = MUL_STAGES - 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

    // ------------------------------------------------------------------
    // Handshake / arbitration
    // ------------------------------------------------------------------
    logic out_load;
    logic div_done;
    logic mul_win;
    logic mul_adv;
    logic acc_mul;
    logic acc_div;

    logic [MUL_STAGES-1:0] mul_vld;
    logic [XLEN-1:0]       mul_val [MUL_STAGES];
    logic [ROB_W-1:0]      mul_tag [MUL_STAGES];

    div_state_t div_state;
    div_state_t div_next;

    always_comb begin
        out_load     = !out_valid || out_ready;
        div_done     = (div_state == DIV_DONE);
        // The divider has priority; the multiplier head only moves into the
        // result register on cycles the divider does not claim it.
        mul_win      = mul_vld[HEAD] && out_load && !div_done;
        mul_adv      = !mul_vld[HEAD] || mul_win;
        in_ready_mul = mul_adv;
        in_ready_div = (div_state == DIV_IDLE);
        acc_mul      = in_valid && !flush && !in_op[2] && in_ready_mul;
        acc_div      = in_valid && !flush &&  in_op[2] && in_ready_div;
    end

    // ------------------------------------------------------------------
    // Multiplier: product formed at issue, then carried through the pipe
    // ------------------------------------------------------------------
    logic              a_sgn;
    logic              b_sgn;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        // MUL/MULH: signed x signed, MULHSU: signed x unsigned, MULHU: unsigned x unsigned
        a_sgn    = (in_op[1:0] != 2'b11);
        b_sgn    = !in_op[1];
        mul_a    = {{XLEN{a_sgn & in_src1[XLEN-1]}}, in_src1};
        mul_b    = {{XLEN{b_sgn & in_src2[XLEN-1]}}, in_src2};
        mul_prod = mul_a * mul_b;
        mul_res  = (in_op[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_vld <= '0;
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                mul_val[i] <= '0;
                mul_tag[i] <= '0;
            end
        end else if (flush) begin
            mul_vld <= '0;
        end else if (mul_adv) begin
            mul_vld[0] <= acc_mul;
            mul_val[0] <= mul_res;
            mul_tag[0] <= in_rob_idx;
            for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                mul_vld[i] <= mul_vld[i-1];
                mul_val[i] <= mul_val[i-1];
                mul_tag[i] <= mul_tag[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dvsr;
    logic [CNT_W-1:0] cnt;
    logic             q_neg;
    logic             r_neg;
    logic             is_rem;
    logic [ROB_W-1:0] div_tag;
    logic [XLEN-1:0]  div_res;

    logic             div_signed;
    logic             s1_neg;
    logic             s2_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_by_zero;
    logic             div_ovf;
    logic [XLEN-1:0]  spec_res;
    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    rem_sub;
    logic             q_bit;
    logic [XLEN-1:0]  rem_nxt;

    always_comb begin
        div_signed  = !in_op[0];
        s1_neg      = div_signed && in_src1[XLEN-1];
        s2_neg      = div_signed && in_src2[XLEN-1];
        a_mag       = s1_neg ? -in_src1 : in_src1;
        b_mag       = s2_neg ? -in_src2 : in_src2;
        div_by_zero = (in_src2 == '0);
        div_ovf     = div_signed && (in_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_src2 == '1);
        if (div_by_zero) begin
            spec_res = in_op[1] ? in_src1 : '1;
        end else begin
            spec_res = in_op[1] ? '0 : in_src1;
        end

        // Restoring step: shift next dividend bit in, subtract if it fits.
        // rem < dvsr always holds, so the XLEN+1 bit difference has its top
        // bit set exactly when the trial subtraction goes negative.
        rem_sh  = {rem, quo[XLEN-1]};
        rem_sub = rem_sh - {1'b0, dvsr};
        q_bit   = !rem_sub[XLEN];
        rem_nxt = q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    end

    always_comb begin
        div_next = div_state;
        case (div_state)
            DIV_IDLE: if (acc_div) div_next = (div_by_zero || div_ovf) ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (cnt == CNT_W'(XLEN - 1)) div_next = DIV_FIX;
            DIV_FIX:  div_next = DIV_DONE;
            DIV_DONE: if (out_load) div_next = DIV_IDLE;
            default:  div_next = DIV_IDLE;
        endcase
        if (flush) div_next = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_state <= DIV_IDLE;
        end else begin
            div_state <= div_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            cnt     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            is_rem  <= 1'b0;
            div_tag <= '0;
            div_res <= '0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (acc_div) begin
                        quo     <= a_mag;
                        rem     <= '0;
                        dvsr    <= b_mag;
                        cnt     <= '0;
                        q_neg   <= s1_neg ^ s2_neg;
                        r_neg   <= s1_neg;
                        is_rem  <= in_op[1];
                        div_tag <= in_rob_idx;
                        div_res <= spec_res;
                    end
                end
                DIV_RUN: begin
                    quo <= {quo[XLEN-2:0], q_bit};
                    rem <= rem_nxt;
                    cnt <= cnt + CNT_W'(1);
                end
                DIV_FIX: begin
                    if (is_rem) begin
                        div_res <= r_neg ? -rem : rem;
                    end else begin
                        div_res <= q_neg ? -quo : quo;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_value    <= '0;
            out_dest_rob <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_load) begin
            if (div_done) begin
                out_valid    <= 1'b1;
                out_value    <= div_res;
                out_dest_rob <= div_tag;
            end else if (mul_vld[HEAD]) begin
                out_valid    <= 1'b1;
                out_value    <= mul_val[HEAD];
                out_dest_rob <= mul_tag[HEAD];
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_fu.sv
// tb_muldiv_fu: self-checking bench for muldiv_fu.
//   Directed RV32M vectors, backpressure, flush and reset cases, then
//   randomized traffic scored against an arithmetic reference model.
module tb_muldiv_fu;

    localparam int XLEN       = 32;
    localparam int ROB_W      = 4;
    localparam int MUL_STAGES = 3;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             flush      = 1'b0;
    logic             in_valid   = 1'b0;
    logic [2:0]       in_op      = '0;
    logic [XLEN-1:0]  in_src1    = '0;
    logic [XLEN-1:0]  in_src2    = '0;
    logic [ROB_W-1:0] in_rob_idx = '0;
    logic             in_ready_mul;
    logic             in_ready_div;
    logic             out_valid;
    logic             out_ready  = 1'b1;
    logic [XLEN-1:0]  out_value;
    logic [ROB_W-1:0] out_dest_rob;

    muldiv_fu #(
        .XLEN      (XLEN),
        .ROB_W     (ROB_W),
        .MUL_STAGES(MUL_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_op       (in_op),
        .in_src1     (in_src1),
        .in_src2     (in_src2),
        .in_rob_idx  (in_rob_idx),
        .in_ready_mul(in_ready_mul),
        .in_ready_div(in_ready_div),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_dest_rob(out_dest_rob)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CDB grant: random or forced level, updated just after each edge
    bit rand_rdy  = 1'b0;
    bit force_rdy = 1'b1;
    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the ISA definitions
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Scoreboard indexed by ROB tag
    logic [31:0] exp_val [16];
    bit          pend    [16];
    bit          is_mul  [16];
    int          acc_cyc [16];
    int          exp_lat [16];
    int          mul_q[$];
    int          cur_lat = -1;
    int          xfers   = 0;
    logic [31:0] last_val = '0;
    logic [3:0]  last_tag = '0;
    logic [3:0]  next_tag = '0;
    bit          seen     = 1'b0;
    bit          hold_ok  = 1'b0;
    logic [31:0] hold_val = '0;
    logic [3:0]  hold_tag = '0;

    function automatic int npend();
        int n = 0;
        for (int i = 0; i < 16; i++) n += pend[i] ? 1 : 0;
        return n;
    endfunction

    // Monitor: mid-cycle sampling of accepts and result transfers
    always @(negedge clk) begin
        int t;
        if (!rst_n || flush) begin
            for (int i = 0; i < 16; i++) pend[i] = 1'b0;
            mul_q.delete();
            seen    = 1'b0;
            hold_ok = 1'b0;
        end else begin
            if (hold_ok && !out_valid) begin
                check("hold_valid", out_valid, 1);
                hold_ok = 1'b0;
            end
            if (out_valid) begin
                t = int'(out_dest_rob);
                if (!seen) begin
                    seen = 1'b1;
                    if (pend[t] && exp_lat[t] >= 0) check("latency", cyc - acc_cyc[t], exp_lat[t]);
                end
                if (hold_ok) begin
                    check("hold_value", out_value, hold_val);
                    check("hold_tag", out_dest_rob, hold_tag);
                end
                if (out_ready) begin
                    check("tag_pending", pend[t], 1);
                    if (pend[t]) begin
                        check("value", out_value, exp_val[t]);
                        if (is_mul[t] && mul_q.size() > 0) begin
                            check("mul_order", t, mul_q[0]);
                            void'(mul_q.pop_front());
                        end
                    end
                    pend[t]  = 1'b0;
                    last_val = out_value;
                    last_tag = out_dest_rob;
                    xfers++;
                    seen     = 1'b0;
                    hold_ok  = 1'b0;
                end else begin
                    hold_ok  = 1'b1;
                    hold_val = out_value;
                    hold_tag = out_dest_rob;
                end
            end
            if (in_valid && (in_op[2] ? in_ready_div : in_ready_mul)) begin
                t = int'(in_rob_idx);
                exp_val[t] = ref_model(in_op, in_src1, in_src2);
                pend[t]    = 1'b1;
                is_mul[t]  = !in_op[2];
                acc_cyc[t] = cyc + 1;
                exp_lat[t] = cur_lat;
                if (!in_op[2]) mul_q.push_back(t);
            end
        end
    end

    // Present one op and hold it until accepted; returns just after the accept edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
        int n;
        bit acc;
        n = 0;
        while (pend[next_tag] && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 1000) check("tag_wait_timeout", 0, 1);
        cur_lat    = lat;
        in_valid   = 1'b1;
        in_op      = op;
        in_src1    = a;
        in_src2    = b;
        in_rob_idx = next_tag;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in_op[2] ? in_ready_div : in_ready_mul;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
        next_tag = next_tag + 4'd1;
    endtask

    task automatic drain();
        int n = 0;
        while ((npend() != 0 || out_valid) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check("drain_left", npend(), 0);
    endtask

    task automatic set_ready(input bit v);
        force_rdy = v;
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] t;
        int busy;
        int ov;
        int xs;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_tag", out_dest_rob, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready_mul", in_ready_mul, 1);
        check("rst_ready_div", in_ready_div, 1);

        // T1
        t = next_tag;
        issue(3'b000, 32'd7, 32'hFFFFFFFD, MUL_STAGES);
        drain();
        check("t1_value", last_val, 32'hFFFFFFEB);
        check("t1_tag", last_tag, t);

        // T2
        issue(3'b001, 32'h80000000, 32'h80000000, MUL_STAGES); drain();
        check("t2_mulh", last_val, 32'h40000000);
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_STAGES); drain();
        check("t2_mulhu", last_val, 32'hFFFFFFFE);
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_STAGES); drain();
        check("t2_mulhsu", last_val, 32'hFFFFFFFF);

        // T3
        issue(3'b100, 32'hFFFFFFF9, 32'd2, XLEN + 2);
        busy = 0;
        repeat (XLEN + 1) begin @(negedge clk); busy += in_ready_div ? 1 : 0; end
        check("t3_div_busy", busy, 0);
        @(posedge clk); #1;
        drain();
        check("t3_div", last_val, 32'hFFFFFFFD);
        issue(3'b110, 32'hFFFFFFF9, 32'd2, XLEN + 2);
        busy = 0;
        repeat (XLEN + 1) begin @(negedge clk); busy += in_ready_div ? 1 : 0; end
        check("t3_rem_busy", busy, 0);
        @(posedge clk); #1;
        drain();
        check("t3_rem", last_val, 32'hFFFFFFFF);

        // T4: special cases
        issue(3'b101, 32'd5, 32'd0, 1); drain();
        check("t4_divu_0", last_val, 32'hFFFFFFFF);
        issue(3'b110, 32'd5, 32'd0, 1); drain();
        check("t4_rem_0", last_val, 32'd5);
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 1); drain();
        check("t4_div_ovf", last_val, 32'h80000000);
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 1); drain();
        check("t4_rem_ovf", last_val, 32'd0);

        // T5: backpressure with four MULs
        set_ready(1'b0);
        xs = xfers;
        t  = next_tag;
        for (int i = 0; i < 4; i++) issue(3'b000, 32'(i + 2), 32'(1000 + i), -1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t5_ready_mul", in_ready_mul, 0);
        check("t5_out_valid", out_valid, 1);
        check("t5_head_tag", out_dest_rob, t);
        repeat (8) @(posedge clk);
        #1;
        set_ready(1'b1);
        drain();
        check("t5_xfers", xfers - xs, 4);

        // T6: flush during a divide with MULs in flight
        issue(3'b100, 32'd1000, 32'd7, -1);
        repeat (7) @(posedge clk);
        #1;
        issue(3'b000, 32'd3, 32'd3, -1);
        issue(3'b001, 32'd4, 32'd4, -1);
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_op      = 3'b000;
        in_src1    = 32'd9;
        in_src2    = 32'd9;
        in_rob_idx = next_tag;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_ready_div", in_ready_div, 1);
        check("t6_out_valid", out_valid, 0);
        ov = 0;
        repeat (40) begin @(negedge clk); ov += out_valid ? 1 : 0; end
        check("t6_no_out", ov, 0);
        @(posedge clk); #1;
        check("t6_pending", npend(), 0);

        // Asynchronous reset mid-operation
        set_ready(1'b0);
        issue(3'b000, 32'd3, 32'd5, -1);
        issue(3'b101, 32'd100, 32'd7, -1);
        repeat (5) @(posedge clk);
        #3;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_value", out_value, 32'd15);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_value", out_value, 0);
        check("arst_out_tag", out_dest_rob, 0);
        check("arst_ready_div", in_ready_div, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ready(1'b1);

        // Randomized traffic
        rand_rdy = 1'b1;
        for (int k = 0; k < 80; k++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), -1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_rdy  = 1'b0;
        force_rdy = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
